// File: rtl/mem_access_stage_if.sv
// Signal bundle for the MEM stage: EXE-side handshake, data-memory req/ack bus and WB result.
// master = the stage itself, slave = its surroundings (EXE, data memory, WB).
interface mem_access_stage_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_instruction;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_write_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] wb_instruction;
   logic [31:0] wb_data;
   logic        wb_err;

   modport master (
      input  ex_valid, ex_instruction, ex_alu_result, ex_write_data,
      input  dmem_ack, dmem_rdata,
      output ex_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output wb_valid, wb_instruction, wb_data, wb_err
   );

   modport slave (
      output ex_valid, ex_instruction, ex_alu_result, ex_write_data,
      output dmem_ack, dmem_rdata,
      input  ex_ready,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  wb_valid, wb_instruction, wb_data, wb_err
   );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS MEM pipeline stage: runs lw/sw over a req/ack data-memory bus with a timeout abort.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | ex_ready=1; accepts from EXE, non-memory/misaligned retire next edge
//   ST_WAIT | dmem_req held, counting cycles until ack or TIMEOUT abort
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input logic clk,
   input logic rst,
   mem_access_stage_if.master bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2B;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      instr_q, instr_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             wb_valid_q, wb_valid_d;
   logic [31:0]      wb_instr_q, wb_instr_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             wb_err_q, wb_err_d;

   logic [5:0] ex_op;
   logic       ex_is_mem;
   logic       ex_aligned;
   logic       waiting_lw;

   assign ex_op      = bus.ex_instruction[31:26];
   assign ex_is_mem  = (ex_op == OP_LW) || (ex_op == OP_SW);
   assign ex_aligned = (bus.ex_alu_result[1:0] == 2'b00);
   assign waiting_lw = (instr_q[31:26] == OP_LW);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         instr_q    <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_instr_q <= '0;
         wb_data_q  <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_instr_q <= wb_instr_d;
         wb_data_q  <= wb_data_d;
         wb_err_q   <= wb_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      instr_d    = instr_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_valid_d = 1'b0;
      wb_instr_d = wb_instr_q;
      wb_data_d  = wb_data_q;
      wb_err_d   = wb_err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.ex_valid) begin
               if (!ex_is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_instr_d = bus.ex_instruction;
                  wb_data_d  = bus.ex_alu_result;
                  wb_err_d   = 1'b0;
               end else if (!ex_aligned) begin
                  wb_valid_d = 1'b1;
                  wb_instr_d = bus.ex_instruction;
                  wb_data_d  = '0;
                  wb_err_d   = 1'b1;
               end else begin
                  instr_d = bus.ex_instruction;
                  addr_d  = bus.ex_alu_result;
                  wdata_d = bus.ex_write_data;
                  we_d    = (ex_op == OP_SW);
                  req_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // ack takes priority over a timeout landing in the same cycle
            if (bus.dmem_ack) begin
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_instr_d = instr_q;
               wb_data_d  = waiting_lw ? bus.dmem_rdata : addr_q;
               wb_err_d   = 1'b0;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_instr_d = instr_q;
               wb_data_d  = '0;
               wb_err_d   = 1'b1;
               cnt_d      = '0;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.ex_ready       = (state_q == ST_IDLE);
   assign bus.dmem_req       = req_q;
   assign bus.dmem_we        = we_q;
   assign bus.dmem_addr      = addr_q;
   assign bus.dmem_wdata     = wdata_q;
   assign bus.wb_valid       = wb_valid_q;
   assign bus.wb_instruction = wb_instr_q;
   assign bus.wb_data        = wb_data_q;
   assign bus.wb_err         = wb_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random lw/sw/other traffic against a
// transaction-level model of the expected WB result and memory-bus behaviour.
module tb_mem_access_stage;
   localparam int TO = 16;
   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2B;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [31:0] last_wb_data = '0;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with the stage idle; returns at the falling edge of the WB cycle.
   // ack_lat = req cycles without ack before the ack cycle; >= TO means the memory never answers.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] wd,
                          input int ack_lat, input logic [31:0] rdata);
      logic [31:0] instr;
      logic        is_lw, is_mem, mis, timed_out, exp_err;
      logic [31:0] exp_data;
      instr  = {op, 26'($urandom)};
      is_lw  = (op == OP_LW);
      is_mem = is_lw || (op == OP_SW);
      mis    = (alu[1:0] != 2'b00);
      check("ex_ready_before", 32'(bus.ex_ready), 32'd1);
      bus.ex_valid       = 1'b1;
      bus.ex_instruction = instr;
      bus.ex_alu_result  = alu;
      bus.ex_write_data  = wd;
      @(posedge clk);
      #1;
      bus.ex_valid       = 1'b0;
      bus.ex_instruction = $urandom;
      bus.ex_alu_result  = $urandom;
      bus.ex_write_data  = $urandom;
      if (!is_mem || mis) begin
         exp_err  = is_mem;
         exp_data = is_mem ? 32'd0 : alu;
      end else begin
         timed_out = (ack_lat >= TO);
         for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check("dmem_req_high", 32'(bus.dmem_req), 32'd1);
            check("dmem_addr", bus.dmem_addr, alu);
            check("dmem_we", 32'(bus.dmem_we), 32'(!is_lw));
            check("dmem_wdata", bus.dmem_wdata, wd);
            check("ex_ready_wait", 32'(bus.ex_ready), 32'd0);
            check("wb_valid_wait", 32'(bus.wb_valid), 32'd0);
            if (k == ack_lat) begin
               bus.dmem_ack   = 1'b1;
               bus.dmem_rdata = rdata;
            end
            @(posedge clk);
            #1;
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = $urandom;
            if (k == ack_lat) break;
         end
         exp_err  = timed_out;
         exp_data = timed_out ? 32'd0 : (is_lw ? rdata : alu);
      end
      @(negedge clk);
      check("wb_valid", 32'(bus.wb_valid), 32'd1);
      check("wb_err", 32'(bus.wb_err), 32'(exp_err));
      check("wb_data", bus.wb_data, exp_data);
      check("wb_instruction", bus.wb_instruction, instr);
      check("dmem_req_low", 32'(bus.dmem_req), 32'd0);
      check("ex_ready_after", 32'(bus.ex_ready), 32'd1);
      last_wb_data = exp_data;
   endtask

   // Idle cycles with stray acks, which must be ignored.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.dmem_ack   = 1'($urandom);
         bus.dmem_rdata = $urandom;
         @(posedge clk);
         #1;
         bus.dmem_ack = 1'b0;
         @(negedge clk);
         check("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
         check("idle_dmem_req", 32'(bus.dmem_req), 32'd0);
         check("idle_wb_data_hold", bus.wb_data, last_wb_data);
      end
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] alu;
      int          sel;
      bus.ex_valid       = 1'b0;
      bus.ex_instruction = '0;
      bus.ex_alu_result  = '0;
      bus.ex_write_data  = '0;
      bus.dmem_ack       = 1'b0;
      bus.dmem_rdata     = '0;

      #12;
      check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
      check("rst_dmem_addr", bus.dmem_addr, 32'd0);
      check("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
      check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("rst_wb_err", 32'(bus.wb_err), 32'd0);
      check("rst_wb_data", bus.wb_data, 32'd0);
      check("rst_wb_instruction", bus.wb_instruction, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ex_ready", 32'(bus.ex_ready), 32'd1);

      run_txn(6'h00, 32'h10, 32'h0, 0, 32'h0);
      idle_cycles(2);
      run_txn(OP_LW, 32'h40, 32'h0, 2, 32'hDEADBEEF);
      run_txn(OP_SW, 32'h44, 32'h1234, 0, 32'h5555AAAA);
      run_txn(6'h00, 32'h77, 32'h0, 0, 32'h0);
      run_txn(6'h08, 32'h1234_5678, 32'h0, 0, 32'h0);
      run_txn(OP_LW, 32'h42, 32'h0, 0, 32'h0);
      run_txn(OP_SW, 32'h103, 32'h9, 0, 32'h0);
      idle_cycles(1);
      run_txn(OP_LW, 32'h80, 32'h0, TO, 32'h0);
      run_txn(OP_LW, 32'h84, 32'h0, TO - 1, 32'hCAFEF00D);
      run_txn(OP_SW, 32'h88, 32'hABCD, TO - 2, 32'h0);
      run_txn(OP_SW, 32'h8C, 32'h4321, TO + 3, 32'h0);

      for (int t = 0; t < 40; t++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0) op = OP_LW;
         else if (sel == 1) op = OP_SW;
         else begin
            op = 6'($urandom);
            while (op == OP_LW || op == OP_SW) op = 6'($urandom);
         end
         alu = $urandom;
         if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
         run_txn(op, alu, $urandom, $urandom_range(0, TO + 2), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end

      // Reset in the middle of an outstanding load.
      bus.ex_valid       = 1'b1;
      bus.ex_instruction = {OP_LW, 26'h0};
      bus.ex_alu_result  = 32'h200;
      @(posedge clk);
      #1;
      bus.ex_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_dmem_req", 32'(bus.dmem_req), 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      check("async_rst_dmem_addr", bus.dmem_addr, 32'd0);
      check("async_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      #4;
      rst = 1'b1;
      last_wb_data = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
         check("post_rst_ex_ready", 32'(bus.ex_ready), 32'd1);
         check("post_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
      end
      run_txn(OP_LW, 32'h300, 32'h0, 1, 32'h0BAD_CAFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
